// File: rtl/contador_hora_pkg.sv
// contador_hora_pkg: shared state encoding, field-select codes, field limits
// and the wrap helpers used by every time field.
`default_nettype none

package contador_hora_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      PROG = 1'b1
   } estado_t;

   localparam logic [1:0] SEL_SEG  = 2'b00;
   localparam logic [1:0] SEL_MIN  = 2'b01;
   localparam logic [1:0] SEL_HOR  = 2'b10;
   localparam logic [1:0] SEL_NONE = 2'b11;

   localparam int unsigned SEG_MAX = 59;
   localparam int unsigned MIN_MAX = 59;

   // The >= / > guards keep a field inside 0..max even from an illegal value.
   function automatic logic [7:0] inc_wrap(input logic [7:0] v, input logic [7:0] max);
      return (v >= max) ? 8'd0 : v + 8'd1;
   endfunction

   function automatic logic [7:0] dec_wrap(input logic [7:0] v, input logic [7:0] max);
      return ((v == 8'd0) || (v > max)) ? max : v - 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/contador_mod.sv
// contador_mod: one wrapping time field (0..MAX) with carry in/out and
// independent single-step increment/decrement that never carries.
`default_nettype none

module contador_mod
   import contador_hora_pkg::*;
#(
   parameter int unsigned MAX = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc_en,
   input  logic       dec_en,
   input  logic       carry_in,
   output logic [7:0] value,
   output logic       carry_out
);

   localparam logic [7:0] MAX_V = 8'(MAX);

   logic       subir;
   logic       bajar;
   logic [7:0] next_value;

   always_comb begin
      subir      = carry_in | (inc_en & ~dec_en);
      bajar      = dec_en & ~inc_en & ~carry_in;
      next_value = value;
      if (subir) begin
         next_value = inc_wrap(value, MAX_V);
      end else if (bajar) begin
         next_value = dec_wrap(value, MAX_V);
      end
      // Only a run-mode carry ripples onward; set-mode steps stay local.
      carry_out = carry_in & (value == MAX_V);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= 8'd0;
      end else begin
         value <= next_value;
      end
   end

endmodule

`default_nettype wire

// File: rtl/contador_hora.sv
// contador_hora: hh:mm:ss clock with 1 s prescaler, run/set modes and
// edge-detected inc/dec buttons for setting the selected field.
`default_nettype none

module contador_hora
   import contador_hora_pkg::*;
#(
   parameter int unsigned PRESC    = 100000000,
   parameter int unsigned HORA_MAX = 23
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       modo_prog,
   input  logic [1:0] sel,
   input  logic       inc,
   input  logic       dec,
   output logic [7:0] segundos,
   output logic [7:0] minutos,
   output logic [7:0] horas,
   output logic       actualizado,
   output logic       tick
);

   localparam int unsigned   PW        = $clog2(PRESC);
   localparam logic [PW-1:0] PRESC_ULT = PW'(PRESC - 1);

   estado_t       estado;
   estado_t       estado_sig;
   logic [PW-1:0] presc;
   logic          inc_q;
   logic          dec_q;

   logic tick_int;
   logic inc_ok;
   logic dec_ok;
   logic seg_inc, seg_dec;
   logic min_inc, min_dec;
   logic hor_inc, hor_dec;
   logic seg_carry, min_carry, hor_carry;
   logic cambio;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado <= RUN;
      end else begin
         estado <= estado_sig;
      end
   end

   always_comb begin
      estado_sig = estado;
      case (estado)
         RUN:  if (modo_prog)  estado_sig = PROG;
         PROG: if (!modo_prog) estado_sig = RUN;
      endcase
   end

   // Held at 0 in PROG so the first tick after leaving it is a full period away.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
      end else if ((estado == PROG) || (presc == PRESC_ULT)) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   always_comb begin
      tick_int = (estado == RUN) && (presc == PRESC_ULT);
      inc_ok   = (estado == PROG) && (inc & ~inc_q) && !(dec & ~dec_q);
      dec_ok   = (estado == PROG) && (dec & ~dec_q) && !(inc & ~inc_q);
      seg_inc  = inc_ok && (sel == SEL_SEG);
      seg_dec  = dec_ok && (sel == SEL_SEG);
      min_inc  = inc_ok && (sel == SEL_MIN);
      min_dec  = dec_ok && (sel == SEL_MIN);
      hor_inc  = inc_ok && (sel == SEL_HOR);
      hor_dec  = dec_ok && (sel == SEL_HOR);
      cambio   = tick_int | seg_inc | seg_dec | min_inc | min_dec
               | hor_inc | hor_dec | hor_carry;
   end

   // Edge history follows the buttons in both modes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inc_q       <= 1'b0;
         dec_q       <= 1'b0;
         tick        <= 1'b0;
         actualizado <= 1'b0;
      end else begin
         inc_q       <= inc;
         dec_q       <= dec;
         tick        <= tick_int;
         actualizado <= cambio;
      end
   end

   contador_mod #(.MAX(SEG_MAX)) u_segundos (
      .clk       (clk),
      .reset     (reset),
      .inc_en    (seg_inc),
      .dec_en    (seg_dec),
      .carry_in  (tick_int),
      .value     (segundos),
      .carry_out (seg_carry)
   );

   contador_mod #(.MAX(MIN_MAX)) u_minutos (
      .clk       (clk),
      .reset     (reset),
      .inc_en    (min_inc),
      .dec_en    (min_dec),
      .carry_in  (seg_carry),
      .value     (minutos),
      .carry_out (min_carry)
   );

   contador_mod #(.MAX(HORA_MAX)) u_horas (
      .clk       (clk),
      .reset     (reset),
      .inc_en    (hor_inc),
      .dec_en    (hor_dec),
      .carry_in  (min_carry),
      .value     (horas),
      .carry_out (hor_carry)
   );

endmodule

`default_nettype wire

// File: tb/tb_contador_hora.sv
// tb_contador_hora: directed checks of contador_hora with a 4-cycle tick.
`default_nettype none

module tb_contador_hora;

   localparam int unsigned PRESC    = 4;
   localparam int unsigned HORA_MAX = 23;
   localparam logic [1:0]  S_SEG    = 2'b00;
   localparam logic [1:0]  S_MIN    = 2'b01;
   localparam logic [1:0]  S_HOR    = 2'b10;
   localparam logic [1:0]  S_NONE   = 2'b11;

   logic       clk = 1'b0;
   logic       reset;
   logic       modo_prog;
   logic [1:0] sel;
   logic       inc;
   logic       dec;
   logic [7:0] segundos;
   logic [7:0] minutos;
   logic [7:0] horas;
   logic       actualizado;
   logic       tick;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   contador_hora #(
      .PRESC    (PRESC),
      .HORA_MAX (HORA_MAX)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .modo_prog   (modo_prog),
      .sel         (sel),
      .inc         (inc),
      .dec         (dec),
      .segundos    (segundos),
      .minutos     (minutos),
      .horas       (horas),
      .actualizado (actualizado),
      .tick        (tick)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_hora(input string tag, input int h, input int m, input int s);
      chk({tag, ".horas"},    32'(horas),    32'(h));
      chk({tag, ".minutos"},  32'(minutos),  32'(m));
      chk({tag, ".segundos"}, 32'(segundos), 32'(s));
   endtask

   task automatic ciclos(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic contar_act(input int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         if (actualizado === 1'b1) c++;
      end
   endtask

   task automatic pulsar_inc(input logic [1:0] s);
      sel = s;
      inc = 1'b1;
      @(negedge clk);
      inc = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulsar_dec(input logic [1:0] s);
      sel = s;
      dec = 1'b1;
      @(negedge clk);
      dec = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int n;
      int n2;

      // Reset state
      reset     = 1'b1;
      modo_prog = 1'b0;
      sel       = S_NONE;
      inc       = 1'b0;
      dec       = 1'b0;
      ciclos(2);
      chk_hora("reset", 0, 0, 0);
      chk("reset.actualizado", 32'(actualizado), 32'd0);
      chk("reset.tick", 32'(tick), 32'd0);
      reset = 1'b0;

      // 59 ticks of 4 cycles reach 00:00:59 at cycle 236
      ciclos(235);
      chk("run.seg_235", 32'(segundos), 32'd58);
      ciclos(1);
      chk_hora("run.236", 0, 0, 59);
      chk("run.tick_236", 32'(tick), 32'd1);
      n = 0;
      for (int i = 237; i <= 241; i++) begin
         @(negedge clk);
         if (actualizado === 1'b1) n++;
         if (i == 240) begin
            chk_hora("run.240", 0, 1, 0);
            chk("run.tick_240", 32'(tick), 32'd1);
         end
      end
      chk("run.act_pulses", 32'(n), 32'd1);

      // Preload 23:59:58 from 00:01:00 using wrapping decrements
      modo_prog = 1'b1;
      ciclos(1);
      pulsar_dec(S_HOR);
      chk("prog.hor_wrap_dn", 32'(horas), 32'd23);
      pulsar_dec(S_MIN);
      pulsar_dec(S_MIN);
      pulsar_dec(S_SEG);
      pulsar_dec(S_SEG);
      chk_hora("prog.preload", 23, 59, 58);

      // Back to RUN: first tick a full period later, then day rollover
      modo_prog = 1'b0;
      ciclos(1);
      ciclos(3);
      chk("rollover.seg_pre", 32'(segundos), 32'd58);
      chk("rollover.tick_pre", 32'(tick), 32'd0);
      ciclos(1);
      chk_hora("rollover.first", 23, 59, 59);
      chk("rollover.tick_first", 32'(tick), 32'd1);
      ciclos(4);
      chk_hora("rollover.midnight", 0, 0, 0);
      chk("rollover.act", 32'(actualizado), 32'd1);

      // One held decrement press on minutes
      modo_prog = 1'b1;
      ciclos(1);
      sel = S_MIN;
      dec = 1'b1;
      contar_act(10, n);
      dec = 1'b0;
      contar_act(2, n2);
      chk_hora("held_dec", 0, 59, 0);
      chk("held_dec.act_pulses", 32'(n + n2), 32'd1);

      // Simultaneous edges and sel=11 change nothing
      sel = S_HOR;
      inc = 1'b1;
      dec = 1'b1;
      contar_act(3, n);
      inc = 1'b0;
      dec = 1'b0;
      ciclos(1);
      chk("both.horas", 32'(horas), 32'd0);
      chk("both.act_pulses", 32'(n), 32'd0);
      sel = S_NONE;
      inc = 1'b1;
      contar_act(2, n);
      inc = 1'b0;
      ciclos(1);
      chk_hora("sel_none", 0, 59, 0);
      chk("sel_none.act_pulses", 32'(n), 32'd0);

      // Field-local wrap without carry or borrow
      pulsar_dec(S_HOR);
      chk("wrap.hor_dn", 32'(horas), 32'd23);
      pulsar_inc(S_HOR);
      chk("wrap.hor_up", 32'(horas), 32'd0);
      pulsar_dec(S_SEG);
      pulsar_inc(S_SEG);
      chk_hora("wrap.seg_up_nocarry", 0, 59, 0);
      pulsar_inc(S_MIN);
      chk_hora("wrap.min_up_nocarry", 0, 0, 0);

      // Set 12:34:56 then reset asynchronously between edges
      for (int i = 0; i < 12; i++) pulsar_inc(S_HOR);
      for (int i = 0; i < 34; i++) pulsar_inc(S_MIN);
      for (int i = 0; i < 4; i++)  pulsar_dec(S_SEG);
      chk_hora("set_123456", 12, 34, 56);
      #2;
      reset     = 1'b1;
      modo_prog = 1'b0;
      #1;
      chk_hora("async_reset", 0, 0, 0);
      chk("async_reset.act", 32'(actualizado), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ciclos(3);
      chk("post_reset.tick_3", 32'(tick), 32'd0);
      chk("post_reset.seg_3", 32'(segundos), 32'd0);
      ciclos(1);
      chk("post_reset.tick_4", 32'(tick), 32'd1);
      chk("post_reset.seg_4", 32'(segundos), 32'd1);

      // Button held across RUN->PROG gives no edge until re-pressed
      inc = 1'b1;
      ciclos(1);
      modo_prog = 1'b1;
      sel       = S_SEG;
      ciclos(1);
      contar_act(5, n);
      chk("held_switch.seg", 32'(segundos), 32'd1);
      chk("held_switch.act_pulses", 32'(n), 32'd0);
      inc = 1'b0;
      ciclos(1);
      chk("held_switch.seg_rel", 32'(segundos), 32'd1);
      inc = 1'b1;
      ciclos(1);
      chk("held_switch.seg_press", 32'(segundos), 32'd2);
      chk("held_switch.act_press", 32'(actualizado), 32'd1);
      inc = 1'b0;
      ciclos(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/contador_hora.md
CONTADOR_HORA -- requirements
Module: contador_hora

Interface
REQ-001 SHALL have parameter PRESC, default 100000000, meaning clk cycles per 1 s tick (minimum 2).
REQ-002 SHALL have parameter HORA_MAX, default 23, meaning highest hour value before wrap.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port modo_prog  input  1  level; 1 = set-time mode, 0 = run mode.
REQ-006 SHALL have port sel  input  2  field select in set mode: 00 segundos, 01 minutos, 10 horas, 11 none.
REQ-007 SHALL have port inc  input  1  debounced increment button, level.
REQ-008 SHALL have port dec  input  1  debounced decrement button, level.
REQ-009 SHALL have port segundos  output  8  binary seconds, 0..59, registered.
REQ-010 SHALL have port minutos  output  8  binary minutes, 0..59, registered.
REQ-011 SHALL have port horas  output  8  binary hours, 0..HORA_MAX, registered.
REQ-012 SHALL have port actualizado  output  1  one-cycle pulse, asserted in the cycle after any time field changes.
REQ-013 SHALL have port tick  output  1  one-cycle pulse marking each internal 1 s tick.

Function
REQ-014 SHALL implement a prescaler counter 0..PRESC-1; tick asserts for one cycle when the counter equals PRESC-1, then the counter wraps to 0.
REQ-015 SHALL implement two states: RUN (modo_prog=0) and PROG (modo_prog=1); the transition occurs on the first clk edge where modo_prog differs from the current state.
REQ-016 In RUN, on each tick, SHALL increment segundos; 59->0 carries into minutos; minutos 59->0 carries into horas; horas HORA_MAX->0. All carries resolve in the same cycle.
REQ-017 At 23:59:59 + tick, SHALL produce 00:00:00 in one cycle.
REQ-018 In PROG, the prescaler SHALL be held at 0, tick SHALL stay low, and the time SHALL NOT advance.
REQ-019 On PROG->RUN, the prescaler SHALL restart from 0, so the first tick follows exactly PRESC cycles later.
REQ-020 In PROG, SHALL rising-edge-detect inc and dec with a one-cycle registered history; one press SHALL change the selected field by exactly 1, regardless of hold length.
REQ-021 PROG inc/dec SHALL wrap only within the selected field (59->0, 0->59; horas HORA_MAX->0, 0->HORA_MAX), with no carry or borrow into other fields.
REQ-022 Simultaneous inc and dec rising edges SHALL cause no change; sel=11 SHALL cause no change.
REQ-023 inc and dec edges in RUN SHALL be ignored; the edge history SHALL still track the inputs, so a button held across the RUN->PROG switch produces no edge.
REQ-024 actualizado SHALL pulse one cycle after a tick advance or a PROG field change; it SHALL NOT pulse on reset.
REQ-025 Outputs SHALL never exceed their ranges, so the downstream binary-to-BCD converter, valid for 0..59, accepts them directly.

Reset
REQ-026 reset=1 SHALL asynchronously force segundos=0, minutos=0, horas=0, prescaler=0, edge history=0, actualizado=0, tick=0, state=RUN.
REQ-027 Reset asserted mid-operation, including mid-carry or mid-press, SHALL take effect without waiting for clk; after release, the first tick SHALL occur PRESC cycles later if modo_prog=0.

Structure
REQ-028 A shared package SHALL hold the state encoding (RUN, PROG), the sel codes, and the constant SEG_MAX=59 / MIN_MAX=59.
REQ-029 A single sub-module, contador_mod, SHALL implement one wrapping counter field with inputs inc_en, dec_en, carry_in and outputs value and carry_out; it is instantiated three times.

Verification
REQ-030 PRESC=4, reset, modo_prog=0, run 240 cycles -> segundos=59 after 236 cycles; next tick -> segundos=0, minutos=1, actualizado pulses once.
REQ-031 Preload 23:59:58 via PROG, return to RUN, wait 2 ticks -> 23:59:59 then 00:00:00.
REQ-032 PROG, sel=01, minutos=0, one dec press held 10 cycles -> minutos=59, horas unchanged, exactly one actualizado pulse.
REQ-033 PROG, sel=10, inc and dec rising in the same cycle -> horas unchanged, no actualizado; sel=11 with inc press -> no change.
REQ-034 Assert reset asynchronously between clk edges at 12:34:56 -> outputs read 00:00:00 before the next edge; first tick occurs 4 cycles after release.
REQ-035 Hold inc high while switching RUN->PROG -> no field change until inc is released and pressed again.
